// File: rtl/product_decimal_display_if.sv
// rtl/product_decimal_display_if.sv - value capture handshake between multiplier and display stage
interface product_decimal_display_if;
    logic [15:0] value_in;
    logic        value_valid;
    logic        busy;

    modport master (
        output value_in,
        output value_valid,
        input  busy
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output busy
    );
endinterface

// File: rtl/product_decimal_display.sv
// rtl/product_decimal_display.sv - binary to BCD converter driving a 4-digit multiplexed 7-segment display
module product_decimal_display #(
    parameter int REFRESH_DIV = 16,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    product_decimal_display_if.slave bus,
    output logic                     overflow,
    output logic [6:0]               segment,
    output logic [3:0]               segment_select
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;

    logic [19:0] bcd_adj;
    logic [35:0] shifted;

    logic [CW-1:0] refresh_cnt_q;
    logic [1:0]    digit_idx_q, digit_idx_nx;
    logic [3:0]    digit_val;
    logic          digit_blank;
    logic [6:0]    segment_nx;

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign bus.busy = (state_q == CONVERT);
    assign overflow = ovf_q;

    // Add-3 correction on every BCD nibble before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {bcd_adj, shift_q} << 1;

    // Conversion FSM next-state: capture, 16 shift steps, then publish to display registers
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.value_valid) begin
                    shift_d   = bus.value_in;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d     = shifted[35:16];
                shift_d   = shifted[15:0];
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd15) begin
                    disp_d  = shifted[31:16];
                    ovf_d   = |shifted[35:32];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Conversion state and display registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
        end
    end

    // Pick the digit selected after this edge and build its segment pattern,
    // so segment and segment_select always load as a matched pair
    always_comb begin
        digit_idx_nx = (refresh_cnt_q == REFRESH_LAST) ? digit_idx_q + 2'd1 : digit_idx_q;
        digit_val    = disp_q[4*digit_idx_nx +: 4];
        case (digit_idx_nx)
            2'd3:    digit_blank = (disp_q[15:12] == 4'd0);
            2'd2:    digit_blank = (disp_q[15:8] == 8'd0);
            2'd1:    digit_blank = (disp_q[15:4] == 12'd0);
            default: digit_blank = 1'b0;
        endcase
        digit_blank = digit_blank & BLANK_LZ;
        if (ovf_q) begin
            segment_nx = SEG_DASH;
        end else if (digit_blank) begin
            segment_nx = SEG_BLANK;
        end else begin
            segment_nx = decode_digit(digit_val);
        end
    end

    // Free-running digit multiplexer, independent of the conversion engine
    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_cnt_q  <= '0;
            digit_idx_q    <= 2'd0;
            segment_select <= 4'b0001;
            segment        <= SEG_BLANK;
        end else begin
            refresh_cnt_q  <= (refresh_cnt_q == REFRESH_LAST) ? '0 : refresh_cnt_q + CW'(1);
            digit_idx_q    <= digit_idx_nx;
            segment_select <= 4'b0001 << digit_idx_nx;
            segment        <= segment_nx;
        end
    end

endmodule

// File: tb/tb_product_decimal_display.sv
// tb/tb_product_decimal_display.sv - self-checking bench for product_decimal_display
module tb_product_decimal_display;

    localparam int DIV = 3;
    localparam logic [6:0] LUT [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       overflow;
    logic [6:0] segment;
    logic [3:0] segment_select;

    int errors = 0;
    int checks = 0;

    product_decimal_display_if bus();

    product_decimal_display #(
        .REFRESH_DIV (DIV),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .overflow       (overflow),
        .segment        (segment),
        .segment_select (segment_select)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Expected pattern for decimal position pos of value v: dash on overflow,
    // blank when the value has no digit at that position, else the decimal digit.
    function automatic logic [6:0] model_seg(input int v, input int pos);
        int p10;
        p10 = 1;
        for (int i = 0; i < pos; i++) p10 = p10 * 10;
        if (v > 9999) return 7'b0000001;
        if (pos > 0 && v < p10) return 7'b0000000;
        return LUT[(v / p10) % 10];
    endfunction

    function automatic int sel_pos(input logic [3:0] s);
        case (s)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_display(input int v);
        int p;
        p = sel_pos(segment_select);
        check_eq("sel_onehot", 32'(p >= 0), 32'd1);
        if (p >= 0) check_eq($sformatf("seg v=%0d pos=%0d", v, p), 32'(segment), 32'(model_seg(v, p)));
        check_eq("overflow", 32'(overflow), 32'(v > 9999));
    endtask

    task automatic sweep(input int v);
        for (int i = 0; i < 4 * DIV; i++) begin
            check_display(v);
            tick();
        end
    endtask

    // Strobe v, count busy-high cycles, optionally fire an ignored strobe mid-conversion
    task automatic convert(input int v, input bit inject);
        int n;
        bus.value_in    = 16'(v);
        bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (inject && n == 5) begin
                bus.value_in    = 16'd4321;
                bus.value_valid = 1'b1;
            end
            tick();
            bus.value_valid = 1'b0;
        end
        check_eq($sformatf("busy_len v=%0d", v), 32'(n), 32'd16);
        check_eq("ovf_at_done", 32'(overflow), 32'(v > 9999));
        tick();
        sweep(v);
    endtask

    task automatic refresh_check(input int v);
        logic [3:0] prev;
        logic [3:0] cur;
        int n;
        int len;
        prev = segment_select;
        n = 0;
        while (segment_select == prev && n < 10) begin
            tick();
            n++;
        end
        check_eq("refresh_first_change", 32'(segment_select != prev), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cur = segment_select;
            len = 0;
            while (segment_select == cur && len < 10) begin
                check_display(v);
                tick();
                len++;
            end
            check_eq("refresh_hold", 32'(len), 32'(DIV));
            check_eq("refresh_next", 32'(segment_select), 32'({cur[2:0], cur[3]}));
        end
    endtask

    initial begin
        int v;
        int r;
        bus.value_in    = 16'd0;
        bus.value_valid = 1'b0;

        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_sel", 32'(segment_select), 32'b0001);
        check_eq("rst_seg", 32'(segment), 32'd0);
        reset = 1'b0;
        tick();
        check_eq("first_sel", 32'(segment_select), 32'b0001);
        check_eq("first_seg", 32'(segment), 32'b1111110);
        tick();
        check_eq("sel_hold", 32'(segment_select), 32'b0001);
        tick();
        check_eq("sel_first_adv", 32'(segment_select), 32'b0010);
        sweep(0);

        convert(56, 1'b0);
        convert(1005, 1'b0);
        convert(9999, 1'b0);
        convert(10000, 1'b0);
        convert(65025, 1'b0);
        convert(0, 1'b0);
        convert(1234, 1'b1);

        bus.value_in    = 16'd5678;
        bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_sel", 32'(segment_select), 32'b0001);
        check_eq("midrst_seg", 32'(segment), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            check_eq("midrst_idle", 32'(bus.busy), 32'd0);
        end
        sweep(0);

        refresh_check(0);

        for (int i = 0; i < 14; i++) begin
            r = int'($urandom_range(0, 2));
            if (r == 0) v = int'($urandom_range(0, 9));
            else if (r == 1) v = int'($urandom_range(0, 9999));
            else v = int'($urandom_range(0, 65535));
            convert(v, 1'b0);
        end
        refresh_check(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
